// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 15,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 active,
  output logic                 timeout_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic locked, hit, accept, tout, release_lock;
  logic [GW-1:0] last_grant, win, idx;
  logic [CW-1:0] cnt;
  // winner search: lowest offset past last_grant wins; a held lock restricts eligibility to the owner
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
    if (locked) begin
      win = last_grant;
      hit = req_valid[last_grant];
    end
  end
  // next state, handshake and transmitter strobes
  always_comb begin
    accept = state == IDLE && hit;
    tout = state == WAIT_BUSY && !tx_busy && cnt == CW'(BUSY_TIMEOUT - 1);
    release_lock = state == IDLE && locked && !req_valid[last_grant] && !req_lock[last_grant];
    req_ready = accept ? NUM_REQ'(1) << win : '0;
    tx_start = state == START;
    active = state != IDLE;
    state_nx = (state == IDLE) ? (hit ? START : IDLE) :
               (state == START) ? WAIT_BUSY :
               (state == WAIT_BUSY) ? (tx_busy ? WAIT_DONE : (tout ? IDLE : WAIT_BUSY)) :
               (tx_busy ? WAIT_DONE : IDLE);
  end
  // state, captured byte, ownership and busy-wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tx_data <= '0;
      grant_id <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      locked <= 1'b0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      timeout_err <= tout;
      cnt <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
      if (accept) begin
        tx_data <= req_data[{win, 3'b000} +: 8];
        grant_id <= win;
        last_grant <= win;
        locked <= req_lock[win];
      end else if (tout || release_lock) begin
        locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized producers and busy profiles against a transaction-level arbitration model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [1:0] grant_id;
  logic tx_start, active, timeout_err;
  logic tx_busy = 1'b0;
  logic [7:0] tx_data;
  int checks = 0, failures = 0;
  logic [7:0] qd [N][64];
  logic ql [N][64];
  int hd [N], tl [N];
  logic [N-1:0] idle_lock, glitch;
  bit m_locked, exp_to;
  int m_last;
  logic [7:0] m_data;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .grant_id(grant_id),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_last = N - 1;
    exp_to = 0;
    m_data = 8'h00;
    idle_lock = '0;
    glitch = '0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][tl[r] % 64] = d;
    ql[r][tl[r] % 64] = l;
    tl[r]++;
  endtask

  task automatic drive(input bit gl);
    for (int i = 0; i < N; i++) begin
      if (hd[i] != tl[i]) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = qd[i][hd[i] % 64];
        req_lock[i] = ql[i][hd[i] % 64];
      end else begin
        req_valid[i] = gl & glitch[i];
        req_data[8*i +: 8] = (gl & glitch[i]) ? 8'hEE : 8'h00;
        req_lock[i] = idle_lock[i];
      end
    end
  endtask

  function automatic int model_win();
    if (m_locked) return req_valid[m_last] ? m_last : -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (hd[i] != tl[i]) return 0;
    return 1;
  endfunction

  task automatic idle_cycle(output int w);
    drive(0);
    @(negedge clk);
    w = model_win();
    chk("idle_ready", req_ready, (w < 0) ? 0 : (1 << w));
    chk("idle_active", active, 0);
    chk("idle_tx_start", tx_start, 0);
    chk("timeout_err", timeout_err, exp_to);
    exp_to = 0;
    if (w >= 0) begin
      m_last = w;
      m_locked = ql[w][hd[w] % 64];
      m_data = qd[w][hd[w] % 64];
      hd[w]++;
    end else if (m_locked && !req_lock[m_last]) begin
      m_locked = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int d, input int L, input bit gl, input int rst_at);
    int n;
    n = (L == 0) ? 1 + TO : 2 + d + L;
    for (int c = 0; c < n; c++) begin
      tx_busy = (L > 0) && c >= 1 + d && c < 1 + d + L;
      drive(gl && c == 2);
      if (c == rst_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_active", active, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tx_busy = 1'b0;
        model_reset();
        return;
      end
      @(negedge clk);
      chk("tx_start", tx_start, c == 0);
      chk("active", active, 1);
      chk("busy_ready", req_ready, 0);
      chk("tx_data", tx_data, m_data);
      chk("grant_id", grant_id, m_last);
      chk("busy_timeout_err", timeout_err, 0);
      @(posedge clk);
      #1;
    end
    tx_busy = 1'b0;
    exp_to = (L == 0);
    if (L == 0) m_locked = 0;
  endtask

  task automatic xfer(input int d, input int L, input bit gl, input int rst_at, output int w);
    idle_cycle(w);
    if (w >= 0) frame(d, L, gl, rst_at);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    drive(0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int w;
    for (int k = 0; k < 40 && !all_empty(); k++)
      xfer($urandom_range(0, 3), $urandom_range(1, 12), 0, -1, w);
  endtask

  initial begin
    int w;
    model_reset();
    drive(0);
    #12;
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_active", active, 0);
    chk("reset_ready", req_ready, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    push(2, 8'h41, 0);
    xfer(0, 10, 0, -1, w);
    chk("single_gid", grant_id, 2);
    chk("single_data", tx_data, 8'h41);
    idle_cycle(w);

    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'h30 + 8'(i), 0);
      push(i, 8'($urandom), 0);
    end
    for (int k = 0; k < 5; k++) begin
      xfer($urandom_range(0, 3), $urandom_range(1, 12), 0, -1, w);
      chk("rr_order", grant_id, k % N);
    end
    drain();

    push(1, 8'h48, 1);
    xfer(0, 10, 0, -1, w);
    chk("lock_H_gid", grant_id, 1);
    chk("lock_H_data", tx_data, 8'h48);
    idle_lock[1] = 1'b1;
    push(0, 8'($urandom), 0);
    push(0, 8'($urandom), 0);
    repeat (3) idle_cycle(w);
    push(1, 8'h49, 0);
    idle_lock[1] = 1'b0;
    xfer(0, 10, 0, -1, w);
    chk("lock_I_gid", grant_id, 1);
    chk("lock_I_data", tx_data, 8'h49);
    xfer(1, 6, 0, -1, w);
    chk("lock_after_gid", grant_id, 0);
    drain();

    push(2, 8'($urandom), 1);
    xfer(0, 0, 0, -1, w);
    push(3, 8'($urandom), 0);
    xfer(0, 5, 0, -1, w);
    chk("timeout_next_gid", grant_id, 3);
    idle_cycle(w);

    push(1, 8'($urandom), 0);
    glitch = 4'b1000;
    xfer(1, 5, 1, -1, w);
    glitch = '0;
    idle_cycle(w);
    chk("withdrawn_gid", grant_id, 1);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0)
        push($urandom_range(0, N - 1), 8'($urandom), ($urandom_range(0, 3) == 0));
      glitch = N'($urandom);
      xfer($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
           $urandom_range(0, 1) == 1, -1, w);
    end
    glitch = '0;
    drain();
    idle_cycle(w);

    push(1, 8'($urandom), 0);
    xfer(0, 8, 0, 4, w);
    for (int i = 0; i < N; i++) push(i, 8'($urandom), 0);
    xfer(0, 4, 0, -1, w);
    chk("post_reset_gid", grant_id, 0);
    drain();
    idle_cycle(w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ byte producers (debug console, status reporter, loopback echo, etc.). Per-requester valid/ready handshake, round-robin selection, and an optional lock that keeps the transmitter for multi-byte packets. Drives uart_tx's tx_start/tx_data, and tracks tx_busy to sequence one frame at a time. Sits directly between the requesters and the uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start before declaring an error (>=2).
GW, derived = max(1, clog2(NUM_REQ)), width of grant_id. Not user-set.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  bit i: requester i holds a byte.
req_data  in  8*NUM_REQ  byte i at [8i+7:8i], stable while req_valid[i]=1.
req_lock  in  NUM_REQ  bit i: keep ownership after this byte.
req_ready  out  NUM_REQ  bit i: byte i accepted on this edge (combinational, one-hot or zero).
grant_id  out  GW  index of the last accepted requester.
tx_start  out  1  one-cycle start pulse to uart_tx.
tx_data  out  8  byte to uart_tx, held until the next accept.
tx_busy  in  1  busy from uart_tx.
active  out  1  high whenever state != IDLE.
timeout_err  out  1  one-cycle pulse on busy timeout.

Behaviour:
- Reset: state=IDLE; tx_start=0; tx_data=0; grant_id=0; timeout_err=0; locked=0; last_grant=NUM_REQ-1, so requester 0 has first priority. A reset mid-frame aborts immediately. uart_tx shares the reset, so no partial-frame recovery is required.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, unlocked: the winner is the first i with req_valid[i]=1, searching (last_grant+1) mod NUM_REQ upward with wrap. req_ready[winner]=1 combinationally. req_ready is 0 in every other state.
- IDLE, locked: only the owner is eligible. Other requesters wait even if they are valid.
- Accept edge T (valid & ready): tx_data<=req_data[winner]; grant_id<=winner; last_grant<=winner; locked<=req_lock[winner]; state<=START.
- START (cycle T+1): tx_start=1 for exactly this cycle. Next state is WAIT_BUSY, with the timeout counter cleared.
- WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT: pulse timeout_err for 1 cycle, clear locked, go to IDLE.
- WAIT_DONE: if tx_busy=0, go to IDLE. No timeout in this state.
- Back-to-back: the earliest next accept is the IDLE cycle after busy falls. Minimum spacing between tx_start pulses = frame busy time + 3 cycles.
- Lock release:
  - at an accept with req_lock=0 (that byte is the last of the packet); or
  - in IDLE when the owner has req_valid=0 and req_lock=0.
  If the owner holds req_lock=1 with req_valid=0, the arbiter stays idle and keeps the lock.
- Round-robin fairness: while unlocked, any continuously valid requester is served within NUM_REQ accepts.
- req_valid dropping before the accept: no transfer and no state change. The arbiter re-arbitrates combinationally each IDLE cycle.
- active = (state != IDLE).

Test Plan:
- Single byte: req_valid[2]=1, data 8'h41, CLKS_PER_BIT=10 → req_ready[2] high 1 cycle; tx_start one cycle later with tx_data=8'h41; grant_id=2; active falls the cycle after tx_busy falls; uart_tx emits 'A' framed (start, 8'h41 LSB-first, stop).
- Round-robin: all 4 valid continuously with bytes 8'h30..8'h33 → accept order 0,1,2,3,0; each tx_start separated by ≥ the busy period; no requester is skipped.
- Lock: requester 1 sends "HI" with req_lock=1 on 'H', 0 on 'I', while requester 0 stays valid → order H, I from requester 1, then requester 0. Requester 0's req_ready stays 0 while locked.
- Timeout: tie tx_busy=0 and issue one request → timeout_err pulses exactly once, 15 cycles after WAIT_BUSY entry; then IDLE, locked=0, next request accepted normally.
- Reset mid-frame: assert reset_n=0 during WAIT_DONE → tx_start, tx_data, grant_id, timeout_err, active all 0 immediately (async). After release, requester 0 wins first when all are valid.
- Valid withdrawn: pulse req_valid[3] for 1 cycle while another frame is in flight → no accept for requester 3, tx_data unchanged.
